// File: rtl/cpu_run_pkg.sv
// Shared types and constants for the CPU run sequencer.
//   run_state_e  : sequencer states
//   dump_beat_t  : one dump-stream word plus its last flag
//   DEF_*        : default values for the cpu_run_ctrl parameters
package cpu_run_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned DEF_ADDR_W       = 9;
    localparam int unsigned DEF_MEM_WORDS    = 512;
    localparam int unsigned DEF_DRAIN_CYCLES = 4;
    localparam int unsigned DEF_MAX_CYCLES   = 100000;
    localparam int unsigned DEF_CNT_W        = 32;

    // Instruction word the ID stage reports through halt_seen.
    localparam logic [DATA_W-1:0] HALT_WORD = 32'hffffffff;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        DRAIN,
        DUMP,
        DONE
    } run_state_e;

    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } dump_beat_t;

endpackage

// File: rtl/dump_skid_buf.sv
// Two-entry valid/ready buffer between the DMEM read data and the dump stream.
//   clk_i, rst_ni : clock, async active-low reset
//   push_i        : write push_beat_i this cycle (caller guarantees space)
//   pop_ready_i   : downstream ready; a word leaves when valid_o & pop_ready_i
//   valid_o/beat_o: head word, driven from registers only
//   full_o        : both entries occupied
//   afull_o       : at least one entry occupied
module dump_skid_buf
    import cpu_run_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       push_i,
    input  dump_beat_t push_beat_i,
    input  logic       pop_ready_i,
    output logic       valid_o,
    output dump_beat_t beat_o,
    output logic       full_o,
    output logic       afull_o
);

    dump_beat_t mem_q [2];
    logic       wptr_q, wptr_d;
    logic       rptr_q, rptr_d;
    logic [1:0] cnt_q,  cnt_d;
    logic       pop_c;

    assign pop_c   = valid_o && pop_ready_i;
    assign valid_o = (cnt_q != 2'd0);
    assign beat_o  = mem_q[rptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign afull_o = (cnt_q != 2'd0);

    // Pointer and occupancy update; push and pop may coincide.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = ~wptr_q;
        if (pop_c)  rptr_d = ~rptr_q;
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_c);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wptr_q   <= 1'b0;
            rptr_q   <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) mem_q[wptr_q] <= push_beat_i;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run sequencer: loads IMEM from the program stream, releases the CPU from
// reset, counts run cycles until halt (or the cycle limit), drains the
// pipeline, then streams all of DMEM out.
//   CLK, RST_N                    : clock, async active-low reset
//   start                         : begin a sequence (IDLE/DONE only)
//   prog_valid/ready/data/last    : program stream in
//   imem_we/addr/wdata            : IMEM write port
//   cpu_rst_n                     : CPU reset, active-low
//   halt_seen                     : ID stage saw the halt word
//   dmem_re/addr, dmem_rdata      : DMEM read port (data one cycle later)
//   dump_valid/ready/data/last    : DMEM dump stream out
//   busy, done, timeout, cycle_count : status
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    parameter int unsigned MEM_WORDS    = DEF_MEM_WORDS,
    parameter int unsigned DRAIN_CYCLES = DEF_DRAIN_CYCLES,
    parameter int unsigned MAX_CYCLES   = DEF_MAX_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              prog_valid,
    output logic              prog_ready,
    input  logic [31:0]       prog_data,
    input  logic              prog_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    input  logic              halt_seen,
    output logic              dmem_re,
    output logic [ADDR_W-1:0] dmem_addr,
    input  logic [31:0]       dmem_rdata,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [31:0]       dump_data,
    output logic              dump_last,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_count
);

    localparam int unsigned       DCNT_W    = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_WORDS - 1);
    localparam logic [DCNT_W-1:0] DRAIN_END = DCNT_W'(DRAIN_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_LIMIT = CNT_W'(MAX_CYCLES - 1);

    run_state_e        state_q, state_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic              rd_done_q, rd_done_d;
    logic              rvalid_q, rvalid_d;
    logic              rlast_q, rlast_d;
    logic [DCNT_W-1:0] dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout_q, timeout_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic              prog_ready_q, prog_ready_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              issue_c, room_c, pop_c, accept_c;
    logic              buf_valid, buf_full, buf_afull;
    dump_beat_t        buf_beat, push_beat;

    assign push_beat = {rlast_q, dmem_rdata};

    dump_skid_buf u_skid (
        .clk_i       (CLK),
        .rst_ni      (RST_N),
        .push_i      (rvalid_q),
        .push_beat_i (push_beat),
        .pop_ready_i (dump_ready),
        .valid_o     (buf_valid),
        .beat_o      (buf_beat),
        .full_o      (buf_full),
        .afull_o     (buf_afull)
    );

    assign pop_c    = buf_valid && dump_ready;
    assign accept_c = prog_valid && prog_ready_q;
    // A read issued now lands in the buffer one cycle after the word already
    // in flight, so it fits if occupancy + in-flight - pop stays below two.
    assign room_c   = !buf_afull || (!buf_full && (!rvalid_q || pop_c)) ||
                      (pop_c && !rvalid_q);

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        waddr_d      = waddr_q;
        raddr_d      = raddr_q;
        rd_done_d    = rd_done_q;
        dcnt_d       = dcnt_q;
        cnt_d        = cnt_q;
        timeout_d    = timeout_q;
        cpu_rst_n_d  = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        issue_c      = 1'b0;

        // Counts every cycle the CPU is out of reset, saturating.
        if (cpu_rst_n_q && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);

        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = LOAD;
                    waddr_d   = '0;
                    cnt_d     = '0;
                    timeout_d = 1'b0;
                end
            end
            LOAD: begin
                if (accept_c) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = waddr_q;
                    imem_wdata_d = prog_data;
                    waddr_d      = waddr_q + ADDR_W'(1);
                    if (prog_last || (waddr_q == LAST_ADDR)) state_d = RUN;
                end
            end
            RUN: begin
                cpu_rst_n_d = 1'b1;
                dcnt_d      = '0;
                // The CPU is still in reset on the first RUN cycle.
                if (cpu_rst_n_q) begin
                    if (halt_seen) begin
                        state_d = DRAIN;
                    end else if (cnt_q >= CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = DRAIN;
                    end
                end
            end
            DRAIN: begin
                raddr_d   = '0;
                rd_done_d = 1'b0;
                if (dcnt_q == DRAIN_END) begin
                    state_d = DUMP;
                end else begin
                    cpu_rst_n_d = 1'b1;
                    dcnt_d      = dcnt_q + DCNT_W'(1);
                end
            end
            DUMP: begin
                if (!rd_done_q && room_c) begin
                    issue_c = 1'b1;
                    raddr_d = raddr_q + ADDR_W'(1);
                    if (raddr_q == LAST_ADDR) rd_done_d = 1'b1;
                end
                if (pop_c && buf_beat.last) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        rvalid_d     = issue_c;
        rlast_d      = issue_c && (raddr_q == LAST_ADDR);
        busy_d       = (state_d == LOAD) || (state_d == RUN) ||
                       (state_d == DRAIN) || (state_d == DUMP);
        done_d       = (state_d == DONE);
        prog_ready_d = (state_d == LOAD);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            waddr_q      <= '0;
            raddr_q      <= '0;
            rd_done_q    <= 1'b0;
            rvalid_q     <= 1'b0;
            rlast_q      <= 1'b0;
            dcnt_q       <= '0;
            cnt_q        <= '0;
            timeout_q    <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            prog_ready_q <= 1'b0;
            cpu_rst_n_q  <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            waddr_q      <= waddr_d;
            raddr_q      <= raddr_d;
            rd_done_q    <= rd_done_d;
            rvalid_q     <= rvalid_d;
            rlast_q      <= rlast_d;
            dcnt_q       <= dcnt_d;
            cnt_q        <= cnt_d;
            timeout_q    <= timeout_d;
            done_q       <= done_d;
            busy_q       <= busy_d;
            prog_ready_q <= prog_ready_d;
            cpu_rst_n_q  <= cpu_rst_n_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign prog_ready  = prog_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_rst_n   = cpu_rst_n_q;
    // Read strobe is issued in the same cycle the room decision is made so a
    // two-entry buffer sustains one word per cycle.
    assign dmem_re     = issue_c;
    assign dmem_addr   = raddr_q;
    assign dump_valid  = buf_valid;
    assign dump_data   = buf_beat.data;
    assign dump_last   = buf_valid && buf_beat.last;
    assign busy        = busy_q;
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign cycle_count = cnt_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl (small memory, short cycle limit).
module tb_cpu_run_ctrl;

    localparam int ADDR_W = 5;
    localparam int MW     = 16;
    localparam int DRAIN  = 4;
    localparam int MAXC   = 50;
    localparam int BOUND  = 400;

    logic              CLK, RST_N, start;
    logic              prog_valid, prog_ready, prog_last;
    logic [31:0]       prog_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_rst_n, halt_seen;
    logic              dmem_re;
    logic [ADDR_W-1:0] dmem_addr;
    logic [31:0]       dmem_rdata;
    logic              dump_valid, dump_ready, dump_last;
    logic [31:0]       dump_data;
    logic              busy, done, timeout;
    logic [31:0]       cycle_count;

    cpu_run_ctrl #(
        .ADDR_W(ADDR_W), .MEM_WORDS(MW), .DRAIN_CYCLES(DRAIN),
        .MAX_CYCLES(MAXC), .CNT_W(32)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start),
        .prog_valid(prog_valid), .prog_ready(prog_ready),
        .prog_data(prog_data), .prog_last(prog_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst_n(cpu_rst_n), .halt_seen(halt_seen),
        .dmem_re(dmem_re), .dmem_addr(dmem_addr), .dmem_rdata(dmem_rdata),
        .dump_valid(dump_valid), .dump_ready(dump_ready),
        .dump_data(dump_data), .dump_last(dump_last),
        .busy(busy), .done(done), .timeout(timeout), .cycle_count(cycle_count)
    );

    typedef struct {
        int       nw;
        bit       tog;
        bit       use_last;
        int       halt_at;
        bit [3:0] pat;
        bit       noise;
        int       exp_cnt;
        bit       exp_to;
    } vec_t;

    vec_t vecs [7];

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0]        dmem [32];
    logic [ADDR_W+31:0] imem_q [$];
    logic [31:0]        dump_q [$];

    int   run_hi = 0, imem_wr = 0, beats = 0, done_rises = 0;
    int   cyc_n = 0, first_beat = -1, last_beat = -1;
    bit   stall_prev = 0, done_prev = 0;
    logic [31:0] hold_data;
    logic        hold_last;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // DMEM model: read data valid the cycle after dmem_re.
    initial dmem_rdata = '0;
    always @(posedge CLK) if (dmem_re) dmem_rdata <= dmem[dmem_addr];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Output monitor and scoreboard pop side.
    always @(negedge CLK) begin
        cyc_n++;
        if (!RST_N) begin
            stall_prev = 0;
            done_prev  = 0;
        end else begin
            if (cpu_rst_n) run_hi++;
            if (done && !done_prev) done_rises++;
            done_prev = done;
            if (imem_we) begin
                imem_wr++;
                if (imem_q.size() == 0) check("imem_spurious_we", 64'(imem_we), 64'd0);
                else check("imem_write", 64'({imem_addr, imem_wdata}), 64'(imem_q.pop_front()));
            end
            if (stall_prev) begin
                check("dump_hold_valid", 64'(dump_valid), 64'd1);
                check("dump_hold_data", 64'(dump_data), 64'(hold_data));
                check("dump_hold_last", 64'(dump_last), 64'(hold_last));
            end
            stall_prev = dump_valid && !dump_ready;
            hold_data  = dump_data;
            hold_last  = dump_last;
            if (dump_valid && dump_ready) begin
                if (dump_q.size() == 0) check("dump_spurious", 64'(dump_valid), 64'd0);
                else begin
                    check("dump_data", 64'(dump_data), 64'(dump_q.pop_front()));
                    check("dump_last", 64'(dump_last), 64'(beats == MW - 1));
                end
                if (first_beat < 0) first_beat = cyc_n;
                last_beat = cyc_n;
                beats++;
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_seq(input int r);
        vec_t v;
        int   sent, run_cyc;
        bit   seen_hi, fin;
        v = vecs[r];
        imem_q.delete();
        dump_q.delete();
        for (int i = 0; i < MW; i++) begin
            dmem[i] = 32'(i * 3 + r * 1000);
            dump_q.push_back(dmem[i]);
        end
        run_hi = 0; imem_wr = 0; beats = 0; done_rises = 0;
        first_beat = -1; last_beat = -1;
        sent = 0; run_cyc = 0; seen_hi = 0; fin = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        check($sformatf("r%0d_start_busy", r), 64'(busy), 64'd1);
        check($sformatf("r%0d_start_clr", r), 64'({done, timeout, cycle_count}), 64'd0);
        for (int k = 0; k < BOUND && !fin; k++) begin
            if (cpu_rst_n) begin
                run_cyc++;
                seen_hi = 1;
            end
            if (sent < v.nw) begin
                prog_valid = v.tog ? (k % 2 == 0) : 1'b1;
                prog_data  = 32'hA5000000 | 32'(r << 8) | 32'(sent);
                prog_last  = v.use_last && (sent == v.nw - 1);
                if (prog_valid && prog_ready) begin
                    imem_q.push_back({ADDR_W'(sent), prog_data});
                    sent++;
                end
            end else begin
                prog_valid = v.noise;
                prog_data  = 32'hDEADBEEF;
                prog_last  = v.noise;
            end
            halt_seen  = (v.halt_at != 0) && cpu_rst_n && (run_cyc == v.halt_at);
            dump_ready = v.pat[k % 4];
            start      = 1'b0;
            if (v.noise && seen_hi && !cpu_rst_n && !done) begin
                start     = 1'b1;
                halt_seen = 1'b1;
            end
            tick();
            if (done) fin = 1;
        end
        start = 1'b0; halt_seen = 1'b0; prog_valid = 1'b0; prog_last = 1'b0;
        check($sformatf("r%0d_reached_done", r), 64'(fin), 64'd1);
        repeat (3) tick();
        check($sformatf("r%0d_done", r), 64'(done), 64'd1);
        check($sformatf("r%0d_busy", r), 64'(busy), 64'd0);
        check($sformatf("r%0d_done_rises", r), 64'(done_rises), 64'd1);
        check($sformatf("r%0d_cpu_rst_n", r), 64'(cpu_rst_n), 64'd0);
        check($sformatf("r%0d_cycle_count", r), 64'(cycle_count), 64'(v.exp_cnt));
        check($sformatf("r%0d_cpu_hi_cycles", r), 64'(run_hi), 64'(v.exp_cnt));
        check($sformatf("r%0d_timeout", r), 64'(timeout), 64'(v.exp_to));
        check($sformatf("r%0d_imem_writes", r), 64'(imem_wr), 64'(v.nw));
        check($sformatf("r%0d_dump_beats", r), 64'(beats), 64'(MW));
        check($sformatf("r%0d_dump_left", r), 64'(dump_q.size()), 64'd0);
        if (v.pat == 4'hF)
            check($sformatf("r%0d_dump_rate", r), 64'(last_beat - first_beat), 64'(MW - 1));
    endtask

    initial begin
        //            nw tog last halt pat   noise cnt to
        vecs[0] = '{3,  0, 1, 10, 4'hF, 0, 14, 0};
        vecs[1] = '{4,  1, 1,  5, 4'hF, 1,  9, 0};
        vecs[2] = '{2,  0, 1,  0, 4'hF, 0, 54, 1};
        vecs[3] = '{5,  0, 1, 20, 4'h9, 1, 24, 0};
        vecs[4] = '{MW, 1, 0,  1, 4'h9, 0,  5, 0};
        vecs[5] = '{1,  0, 1, 50, 4'h6, 0, 54, 0};
        vecs[6] = '{3,  1, 1, 49, 4'hF, 1, 53, 0};

        RST_N = 1'b0; start = 1'b0; prog_valid = 1'b0; prog_data = '0;
        prog_last = 1'b0; halt_seen = 1'b0; dump_ready = 1'b0;
        repeat (3) tick();
        check("rst_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("rst_status", 64'({busy, done, timeout}), 64'd0);
        check("rst_cycle_count", 64'(cycle_count), 64'd0);
        check("rst_ports", 64'({prog_ready, imem_we, dmem_re, dump_valid, dump_last}), 64'd0);
        RST_N = 1'b1;
        repeat (2) tick();
        check("idle_cpu_rst_n", 64'(cpu_rst_n), 64'd0);

        for (int r = 0; r < 7; r++) run_seq(r);

        // Reset asserted in the middle of RUN.
        imem_q.delete();
        run_hi = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        begin
            int sent;
            sent = 0;
            for (int k = 0; k < 100 && run_hi < 5; k++) begin
                if (sent < 3) begin
                    prog_valid = 1'b1;
                    prog_data  = 32'hC0DE0000 | 32'(sent);
                    prog_last  = (sent == 2);
                    if (prog_ready) begin
                        imem_q.push_back({ADDR_W'(sent), prog_data});
                        sent++;
                    end
                end else begin
                    prog_valid = 1'b0;
                    prog_last  = 1'b0;
                end
                tick();
            end
        end
        check("mid_pre_cpu_rst_n", 64'(cpu_rst_n), 64'd1);
        check("mid_imem_pending", 64'(imem_q.size()), 64'd0);
        RST_N = 1'b0;
        #1;
        check("mid_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("mid_status", 64'({busy, done, timeout, prog_ready}), 64'd0);
        check("mid_cycle_count", 64'(cycle_count), 64'd0);
        check("mid_ports", 64'({imem_we, dmem_re, dump_valid, dump_last}), 64'd0);
        dump_q.delete();
        repeat (2) tick();
        RST_N = 1'b1;
        repeat (3) tick();
        check("mid_idle_cpu_rst_n", 64'(cpu_rst_n), 64'd0);
        check("mid_idle_busy", 64'(busy), 64'd0);
        run_seq(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
